// File: rtl/width_upconv_pack_pkg.sv
// Shared sizing constants and helpers for the narrow-to-wide word packer.
// Default widths match the merge-tree word (MERGW) and the DRAM word (DRAMW).
package width_upconv_pack_pkg;

  localparam int unsigned MERGW = 128;
  localparam int unsigned DRAMW = 512;

  function automatic int unsigned ratio_of(input int unsigned in_w, input int unsigned out_w);
    return out_w / in_w;
  endfunction

  // Lane index width; never narrower than one bit.
  function automatic int unsigned lane_cw(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Lane count width: must hold the value RATIO itself.
  function automatic int unsigned lanes_w(input int unsigned ratio);
    return $clog2(ratio) + 1;
  endfunction

  localparam int unsigned RATIO   = DRAMW / MERGW;
  localparam int unsigned LANE_CW = $clog2(RATIO);
  localparam int unsigned LANES_W = $clog2(RATIO) + 1;

endpackage

// File: rtl/width_upconv_pack_out_stage.sv
// Output holding register for the packer: valid/ready handshake, word/last/lane
// tags and the running count of words taken by the consumer.
module width_upconv_pack_out_stage #(
  parameter int unsigned OUT_W   = 512,
  parameter int unsigned LANES_W = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               ld_i,
  input  logic [OUT_W-1:0]   ld_dot_i,
  input  logic               ld_last_i,
  input  logic [LANES_W-1:0] ld_lanes_i,
  input  logic               dot_rdy_i,
  output logic               dot_en_o,
  output logic [OUT_W-1:0]   dot_o,
  output logic               dot_last_o,
  output logic [LANES_W-1:0] dot_lanes_o,
  output logic [CNT_W-1:0]   wcnt_o,
  output logic               hold_o
);

  logic               dot_en_q, dot_en_d;
  logic [OUT_W-1:0]   dot_q, dot_d;
  logic               dot_last_q, dot_last_d;
  logic [LANES_W-1:0] dot_lanes_q, dot_lanes_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic               xfer;

  assign xfer = dot_en_q && dot_rdy_i;

  // A load is only ever requested when the register is empty or draining this cycle.
  always_comb begin
    dot_en_d    = dot_en_q;
    dot_d       = dot_q;
    dot_last_d  = dot_last_q;
    dot_lanes_d = dot_lanes_q;
    wcnt_d      = wcnt_q;
    if (ld_i) begin
      dot_en_d    = 1'b1;
      dot_d       = ld_dot_i;
      dot_last_d  = ld_last_i;
      dot_lanes_d = ld_lanes_i;
    end else if (xfer) begin
      dot_en_d = 1'b0;
    end
    if (xfer) begin
      wcnt_d = wcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dot_en_q    <= 1'b0;
      dot_q       <= '0;
      dot_last_q  <= 1'b0;
      dot_lanes_q <= '0;
      wcnt_q      <= '0;
    end else begin
      dot_en_q    <= dot_en_d;
      dot_q       <= dot_d;
      dot_last_q  <= dot_last_d;
      dot_lanes_q <= dot_lanes_d;
      wcnt_q      <= wcnt_d;
    end
  end

  assign dot_en_o    = dot_en_q;
  assign dot_o       = dot_q;
  assign dot_last_o  = dot_last_q;
  assign dot_lanes_o = dot_lanes_q;
  assign wcnt_o      = wcnt_q;
  assign hold_o      = dot_en_q && !dot_rdy_i;

endmodule

// File: rtl/width_upconv_pack.sv
// Packs OUT_W/IN_W narrow host words into one wide DRAM word, with backpressure
// on both sides and padded end-of-transfer flush of a short final word.
module width_upconv_pack
  import width_upconv_pack_pkg::*;
#(
  parameter int unsigned IN_W      = MERGW,
  parameter int unsigned OUT_W     = DRAMW,
  parameter bit          LSB_FIRST = 1'b1,
  parameter bit          PAD_BIT   = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                                  CLK,
  input  logic                                  RST_N,
  input  logic                                  din_en,
  output logic                                  din_rdy,
  input  logic [IN_W-1:0]                       din,
  input  logic                                  din_last,
  output logic                                  dot_en,
  input  logic                                  dot_rdy,
  output logic [OUT_W-1:0]                      dot,
  output logic                                  dot_last,
  output logic [lanes_w(ratio_of(IN_W, OUT_W))-1:0] dot_lanes,
  output logic [CNT_W-1:0]                      wcnt
);

  localparam int unsigned Ratio  = ratio_of(IN_W, OUT_W);
  localparam int unsigned LaneCw = lane_cw(Ratio);
  localparam int unsigned LanesW = lanes_w(Ratio);
  localparam logic [LaneCw-1:0] LastLane = LaneCw'(Ratio - 1);

  logic [Ratio-1:0][IN_W-1:0] acc_q, acc_d;
  logic [LaneCw-1:0]          cnt_q, cnt_d;
  logic                       out_hold;
  logic                       at_last, accept, complete;
  logic [OUT_W-1:0]           word;
  logic [LanesW-1:0]          word_lanes;
  logic [IN_W-1:0]            lane_val;

  assign at_last  = (cnt_q == LastLane);
  // Only a completing accept needs the output register free.
  assign din_rdy  = !(out_hold && (at_last || din_last));
  assign accept   = din_en && din_rdy;
  assign complete = accept && (at_last || din_last);

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word       = '0;
    lane_val   = '0;
    word_lanes = LanesW'(cnt_q) + LanesW'(1);
    if (accept) begin
      acc_d[cnt_q] = din;
      cnt_d        = complete ? '0 : cnt_q + LaneCw'(1);
    end
    // Lanes below cnt come from the accumulator, lane cnt is the incoming word,
    // everything above is padding.
    for (int unsigned i = 0; i < Ratio; i++) begin
      if (LaneCw'(i) < cnt_q) begin
        lane_val = acc_q[i];
      end else if (LaneCw'(i) == cnt_q) begin
        lane_val = din;
      end else begin
        lane_val = {IN_W{PAD_BIT}};
      end
      if (LSB_FIRST) begin
        word[i*IN_W +: IN_W] = lane_val;
      end else begin
        word[(Ratio-1-i)*IN_W +: IN_W] = lane_val;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  width_upconv_pack_out_stage #(
    .OUT_W  (OUT_W),
    .LANES_W(LanesW),
    .CNT_W  (CNT_W)
  ) u_out_stage (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ld_i       (complete),
    .ld_dot_i   (word),
    .ld_last_i  (din_last),
    .ld_lanes_i (word_lanes),
    .dot_rdy_i  (dot_rdy),
    .dot_en_o   (dot_en),
    .dot_o      (dot),
    .dot_last_o (dot_last),
    .dot_lanes_o(dot_lanes),
    .wcnt_o     (wcnt),
    .hold_o     (out_hold)
  );

endmodule
